// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the register-file write port and tracks pending writes for RAW/WAW checks.
// Latency 1 cycle to wr_*; requesters are stalled by combinational reqN_ready (round-robin on ties).
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic            last_grant;   // 1: requester 1 won the last transfer
    logic            grant0;
    logic            grant1;
    logic            issue_set;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign issue_ready = (issue_rd == '0) || !pending[issue_rd];
    assign hazard      = ((rs1 != '0) && pending[rs1]) || ((rs2 != '0) && pending[rs2]);
    assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

    // Clear on the commit edge first so a same-edge set on that index wins.
    always_comb begin
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (issue_set) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pending    <= '0;
            last_grant <= 1'b1;
        end else begin
            pending <= pending_nxt;
            wr_en   <= (grant0 && (req0_rd != '0)) || (grant1 && (req1_rd != '0));
            if (grant0) begin
                wr_addr    <= req0_rd;
                wr_data    <= req0_data;
                last_grant <= 1'b0;
            end else if (grant1) begin
                wr_addr    <= req1_rd;
                wr_data    <= req1_data;
                last_grant <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table, reset corner sequence and randomized run against a scoreboard model for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        hazard;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_rd = '0;
    logic [63:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_rd = '0;
    logic [63:0] req1_data = '0;
    logic        req1_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(64), .NREG(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ird, s1, s2;
        logic        v0;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic        e_r0, e_r1, e_ir, e_hz, e_we;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
                       input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [63:0] d1,
                       input logic r0, input logic r1, input logic ir, input logic hz,
                       input logic we, input logic [4:0] wa, input logic [63:0] wd);
        vec_t v;
        v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
        v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
        v.e_r0 = r0; v.e_r1 = r1; v.e_ir = ir; v.e_hz = hz; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
                         input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [63:0] d1);
        issue_valid = iv; issue_rd = ird; rs1 = s1; rs2 = s2;
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: a set of registers awaiting commit, the arbiter's
    // preferred requester, and the write expected on the port this cycle.
    bit          m_pend[32];
    bit          m_pref1;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;

    initial begin
        bit          h0_v, h1_v;
        logic [4:0]  h0_rd, h1_rd;
        logic [63:0] h0_d, h1_d;
        bit          iv, g0, g1, ir;
        logic [4:0]  ird, s1, s2;

        // Directed table: each row is inputs for one cycle and the outputs seen that cycle.
        add(0,0,0,0, 1,3,64'h33, 1,4,64'h44,  1,0,1,0, 0,0,0);
        add(0,0,0,0, 1,3,64'h33, 1,4,64'h44,  0,1,1,0, 1,3,64'h33);
        add(0,0,0,0, 1,3,64'h33, 1,4,64'h44,  1,0,1,0, 1,4,64'h44);
        add(0,0,0,0, 1,3,64'h33, 1,4,64'h44,  0,1,1,0, 1,3,64'h33);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 1,4,64'h44);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(0,0,0,0, 1,5,64'hAA, 0,0,0,       1,0,1,0, 0,0,0);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 1,5,64'hAA);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(1,7,0,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(0,0,7,0, 0,0,0,      1,7,64'h77,  0,1,1,1, 0,0,0);
        add(0,0,7,0, 0,0,0,      0,0,0,       0,0,1,1, 1,7,64'h77);
        add(0,0,7,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(1,0,0,0, 1,0,64'h55, 0,0,0,       1,0,1,0, 0,0,0);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(1,9,0,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(0,0,9,0, 1,9,64'h99, 0,0,0,       1,0,1,1, 0,0,0);
        add(1,9,0,9, 0,0,0,      0,0,0,       0,0,0,1, 1,9,64'h99);
        add(1,9,9,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);
        add(1,9,9,0, 0,0,0,      0,0,0,       0,0,0,1, 0,0,0);
        add(0,0,0,0, 1,1,64'h11, 1,2,64'h22,  0,1,1,0, 0,0,0);
        add(0,0,0,0, 1,1,64'h11, 0,0,0,       1,0,1,0, 1,2,64'h22);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 1,1,64'h11);
        add(0,0,0,0, 0,0,0,      0,0,0,       0,0,1,0, 0,0,0);

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].ird, tbl[i].s1, tbl[i].s2, tbl[i].v0, tbl[i].rd0, tbl[i].d0,
                  tbl[i].v1, tbl[i].rd1, tbl[i].d1);
            #3;
            chk($sformatf("row%0d_req0_ready", i), req0_ready, tbl[i].e_r0);
            chk($sformatf("row%0d_req1_ready", i), req1_ready, tbl[i].e_r1);
            chk($sformatf("row%0d_issue_ready", i), issue_ready, tbl[i].e_ir);
            chk($sformatf("row%0d_hazard", i), hazard, tbl[i].e_hz);
            chk($sformatf("row%0d_wr_en", i), wr_en, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("row%0d_wr_addr", i), wr_addr, tbl[i].e_wa);
                chk($sformatf("row%0d_wr_data", i), wr_data, tbl[i].e_wd);
            end
            next_cycle();
        end

        // Reset asserted while a write is on the port and a register is pending.
        drive(1,6,0,0, 1,6,64'h66, 0,0,0);
        next_cycle();
        drive(0,0,6,9, 0,0,0, 0,0,0);
        #3;
        chk("pre_rst_wr_en", wr_en, 1);
        chk("pre_rst_hazard", hazard, 1);
        reset = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_hazard", hazard, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        next_cycle();
        reset = 1'b1;
        drive(0,0,0,0, 1,2,64'h12, 1,3,64'h13);
        #3;
        chk("postrst_req0_ready", req0_ready, 1);
        chk("postrst_req1_ready", req1_ready, 0);
        next_cycle();
        drive(0,0,0,0, 0,0,0, 0,0,0);
        #3;
        chk("postrst_wr_addr", wr_addr, 2);

        // Randomized phase from a fresh reset.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        foreach (m_pend[k]) m_pend[k] = 0;
        m_pref1 = 0; m_we = 0; m_wa = '0; m_wd = '0;
        h0_v = 0; h1_v = 0; h0_rd = '0; h1_rd = '0; h0_d = '0; h1_d = '0;

        for (int c = 0; c < 3000; c++) begin
            if (!h0_v && $urandom_range(0, 1) == 1) begin
                h0_v = 1; h0_rd = 5'($urandom_range(0, 7)); h0_d = {$urandom, $urandom};
            end
            if (!h1_v && $urandom_range(0, 1) == 1) begin
                h1_v = 1; h1_rd = 5'($urandom_range(0, 7)); h1_d = {$urandom, $urandom};
            end
            iv  = ($urandom_range(0, 2) == 0);
            ird = 5'($urandom_range(0, 7));
            s1  = 5'($urandom_range(0, 7));
            s2  = 5'($urandom_range(0, 7));
            drive(iv, ird, s1, s2, h0_v, h0_rd, h0_d, h1_v, h1_rd, h1_d);

            g0 = h0_v && (!h1_v || !m_pref1);
            g1 = h1_v && !g0;
            ir = (ird == 0) || !m_pend[ird];
            #3;
            chk("rnd_req0_ready", req0_ready, g0);
            chk("rnd_req1_ready", req1_ready, g1);
            chk("rnd_issue_ready", issue_ready, ir);
            chk("rnd_hazard", hazard, (s1 != 0 && m_pend[s1]) || (s2 != 0 && m_pend[s2]));
            chk("rnd_wr_en", wr_en, m_we);
            if (m_we) begin
                chk("rnd_wr_addr", wr_addr, m_wa);
                chk("rnd_wr_data", wr_data, m_wd);
            end

            if (m_we) m_pend[m_wa] = 0;
            if (iv && ir && ird != 0) m_pend[ird] = 1;
            m_we = 0;
            if (g0) begin
                m_we = (h0_rd != 0); m_wa = h0_rd; m_wd = h0_d; m_pref1 = 1; h0_v = 0;
            end else if (g1) begin
                m_we = (h1_rd != 0); m_wa = h1_rd; m_wd = h1_d; m_pref1 = 0; h1_v = 0;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
